// File: rtl/multi_value_control.sv
// N_CH bounded values stepped from debounced active-low buttons, with a channel-select button.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on the inc/dec buttons.
module multi_value_control #(
    parameter int N_CH       = 2,
    parameter int N_BIT      = 9,
    parameter int STEP       = 5,
    parameter int VMIN       = 30,
    parameter int VMAX       = 180,
    parameter int VINIT      = 180,
    parameter int WRAP       = 0,
    parameter int DEB_CYCLES = 50000,
    parameter int RPT_DLY    = 25000000,
    parameter int RPT_PER    = 5000000
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    input  logic                   i_inc_btn,
    input  logic                   i_dec_btn,
    input  logic                   i_sel_btn,
    output logic [N_CH*N_BIT-1:0]  o_values,
    output logic [2:0]             o_sel,
    output logic                   o_update
);
    localparam int W1  = N_BIT + 1;
    localparam int CW  = $clog2(DEB_CYCLES + 1);
    localparam int INC = 0;
    localparam int DEC = 1;
    localparam int SEL = 2;

    generate
        if (N_CH < 1 || N_CH > 8 || DEB_CYCLES < 1 || RPT_DLY < 1 || RPT_PER < 1 ||
            VMIN > VMAX || VINIT < VMIN || VINIT > VMAX || VMAX >= 2**N_BIT) begin : g_param_check
            $error("multi_value_control: illegal parameter set");
        end
    endgenerate

    logic [2:0]    btn_raw, sync_meta, sync_out, deb, deb_d, armed, press;
    logic [1:0]    settle;
    logic [CW-1:0] deb_cnt [3];
    logic [1:0]    rpt;

    assign btn_raw = {i_sel_btn, i_dec_btn, i_inc_btn};

    // A button only becomes armed once it has been seen released after reset, so a
    // button held through reset release cannot produce a press.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            sync_meta <= '1;
            sync_out  <= '1;
            deb       <= '1;
            deb_d     <= '1;
            armed     <= '0;
            settle    <= '0;
            for (int b = 0; b < 3; b++) deb_cnt[b] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
            sync_meta <= btn_raw;
            sync_out  <= sync_meta;
            deb_d     <= deb;
            settle    <= {settle[0], 1'b1};
            for (int b = 0; b < 3; b++) begin
                armed[b] <= armed[b] | (settle[1] & sync_out[b]);
                if (sync_out[b] == deb[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == CW'(DEB_CYCLES - 1)) begin
                    deb[b]     <= sync_out[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign press = ~deb & deb_d & armed;

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RW   = $clog2(RMAX + 1);

    logic [1:0]    rpt_act, rpt_first;
    logic [RW-1:0] rpt_cnt [2];

    always_comb begin
        rpt = '0;
        for (int k = 0; k < 2; k++)
            rpt[k] = rpt_act[k] && !deb[k] && deb[k^1] &&
                     (rpt_cnt[k] == (rpt_first[k] ? RW'(RPT_DLY - 1) : RW'(RPT_PER - 1)));
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            rpt_act   <= '0;
            rpt_first <= '0;
            for (int k = 0; k < 2; k++) rpt_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (press[SEL] || deb[k] || !deb[k^1]) begin
                    rpt_act[k] <= 1'b0;
                    rpt_cnt[k] <= '0;
                end else if (press[k]) begin
                    rpt_act[k]   <= 1'b1;
                    rpt_first[k] <= 1'b1;
                    rpt_cnt[k]   <= '0;
                end else if (rpt[k]) begin
                    rpt_first[k] <= 1'b0;
                    rpt_cnt[k]   <= '0;
                end else if (rpt_act[k]) begin
                    rpt_cnt[k] <= rpt_cnt[k] + 1'b1;
                end
            end
        end
    end
`else
    assign rpt = 2'b00;
`endif

    logic [N_BIT-1:0] vals [N_CH];
    logic [N_BIT-1:0] cur, inc_res, dec_res, nxt;
    logic [W1-1:0]    sum, diff;
    logic             ev_inc, ev_dec, ev_sel, changed;

    assign ev_inc = press[INC] | rpt[INC];
    assign ev_dec = press[DEC] | rpt[DEC];
    assign ev_sel = press[SEL];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cur = '0;
        for (int k = 0; k < N_CH; k++)
            if (o_sel == 3'(k)) cur = vals[k];
        sum     = {1'b0, cur} + W1'(STEP);
        diff    = {1'b0, cur} - W1'(STEP);
        inc_res = sum[N_BIT-1:0];
        dec_res = diff[N_BIT-1:0];
        if (sum > W1'(VMAX))
            inc_res = (WRAP != 0) ? N_BIT'(VMIN) : N_BIT'(VMAX);
        // diff's top bit is the borrow, so a step below zero is caught as below VMIN.
        if (diff[N_BIT] || diff < W1'(VMIN))
            dec_res = (WRAP != 0) ? N_BIT'(VMAX) : N_BIT'(VMIN);
        nxt = cur;
        if (!ev_sel && ev_inc && !ev_dec) nxt = inc_res;
        if (!ev_sel && ev_dec && !ev_inc) nxt = dec_res;
        changed = (nxt != cur);
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            // NOTE: the value array is reset too: the core must read VINIT, never power-up junk.
            for (int k = 0; k < N_CH; k++) vals[k] <= N_BIT'(VINIT);
            o_sel    <= '0;
            o_update <= 1'b0;
        end else begin
            o_update <= changed;
            for (int k = 0; k < N_CH; k++)
                if (changed && o_sel == 3'(k)) vals[k] <= nxt;
            if (ev_sel)
                o_sel <= (o_sel == 3'(N_CH - 1)) ? 3'd0 : o_sel + 3'd1;
        end
    end

    always_comb begin
        o_values = '0;
        for (int k = 0; k < N_CH; k++) o_values[k*N_BIT +: N_BIT] = vals[k];
    end
endmodule

// File: tb/tb_multi_value_control.sv
// Bench for multi_value_control: a saturating and a wrapping instance share the buttons and
// are compared against a press-level model. Repeat checks run only when AUTO_REPEAT_EN is defined.
module tb_multi_value_control;
    localparam int N_CH    = 2;
    localparam int N_BIT   = 9;
    localparam int STEP    = 5;
    localparam int VMIN    = 30;
    localparam int VMAX    = 180;
    localparam int VINIT   = 180;
    localparam int DEB     = 4;
    localparam int RPT_DLY = 20;
    localparam int RPT_PER = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inc_btn = 1'b1, dec_btn = 1'b1, sel_btn = 1'b1;
    logic [N_CH*N_BIT-1:0] values_s, values_w;
    logic [2:0] sel_s, sel_w;
    logic upd_s, upd_w;

    always #5 clk = ~clk;

    multi_value_control #(.N_CH(N_CH), .N_BIT(N_BIT), .STEP(STEP), .VMIN(VMIN), .VMAX(VMAX),
        .VINIT(VINIT), .WRAP(0), .DEB_CYCLES(DEB), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) dut_sat (
        .i_CLK(clk), .i_RST(rst_n), .i_inc_btn(inc_btn), .i_dec_btn(dec_btn), .i_sel_btn(sel_btn),
        .o_values(values_s), .o_sel(sel_s), .o_update(upd_s));

    multi_value_control #(.N_CH(N_CH), .N_BIT(N_BIT), .STEP(STEP), .VMIN(VMIN), .VMAX(VMAX),
        .VINIT(VINIT), .WRAP(1), .DEB_CYCLES(DEB), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) dut_wrap (
        .i_CLK(clk), .i_RST(rst_n), .i_inc_btn(inc_btn), .i_dec_btn(dec_btn), .i_sel_btn(sel_btn),
        .o_values(values_w), .o_sel(sel_w), .o_update(upd_w));

    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0;
    int upd_s_cnt = 0, upd_w_cnt = 0;
    int upd_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (upd_s) begin
            upd_s_cnt++;
            upd_cyc.push_back(cyc);
        end
        if (upd_w) upd_w_cnt++;
    end

    // Press-level reference model: one entry per accepted button event.
    int m_s[N_CH], m_w[N_CH], m_sel;
    int exp_upd_s = 0, exp_upd_w = 0;

    function automatic int step_val(int v, int d, bit wrap);
        int r = v + d;
        if (r > VMAX) return wrap ? VMIN : VMAX;
        if (r < VMIN) return wrap ? VMAX : VMIN;
        return r;
    endfunction

    function automatic logic [N_CH*N_BIT-1:0] pack(bit wrap);
        logic [N_CH*N_BIT-1:0] p = '0;
        for (int k = 0; k < N_CH; k++) p[k*N_BIT +: N_BIT] = N_BIT'(wrap ? m_w[k] : m_s[k]);
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_s[k] = VINIT;
            m_w[k] = VINIT;
        end
        m_sel = 0;
    endtask

    task automatic model_press(bit inc, bit dec, bit sel);
        int ns, nw;
        if (sel) begin
            m_sel = (m_sel + 1) % N_CH;
        end else if (inc ^ dec) begin
            ns = step_val(m_s[m_sel], inc ? STEP : -STEP, 1'b0);
            nw = step_val(m_w[m_sel], inc ? STEP : -STEP, 1'b1);
            if (ns != m_s[m_sel]) exp_upd_s++;
            if (nw != m_w[m_sel]) exp_upd_w++;
            m_s[m_sel] = ns;
            m_w[m_sel] = nw;
        end
    endtask

    task automatic drive(bit inc, bit dec, bit sel, int hold, int gap);
        @(negedge clk);
        inc_btn = ~inc;
        dec_btn = ~dec;
        sel_btn = ~sel;
        repeat (hold) @(negedge clk);
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        sel_btn = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic press(bit inc, bit dec, bit sel);
        drive(inc, dec, sel, $urandom_range(DEB + 3, DEB + 8), DEB + 5);
        model_press(inc, dec, sel);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        sel_btn = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({values_s, values_w, sel_s, sel_w} !== {pack(0), pack(1), 3'(m_sel), 3'(m_sel)})
            $display("FAIL reset_state: got %h %h sel %0d/%0d, expected %h sel 0",
                     values_s, values_w, sel_s, sel_w, pack(0));
        else pass_cnt++;
        total_cnt++;
        if ({upd_s, upd_w} !== 2'b00) $display("FAIL reset_update: got %b%b, expected 00", upd_s, upd_w);
        else pass_cnt++;
    endtask

    task automatic test_clamp_top();
        drive(1, 0, 0, 10, DEB + 5);
        model_press(1, 0, 0);
        total_cnt++;
        if ({values_s, values_w} !== {pack(0), pack(1)})
            $display("FAIL clamp_top_value: got %h %h, expected %h %h", values_s, values_w, pack(0), pack(1));
        else pass_cnt++;
        total_cnt++;
        if (upd_s_cnt !== exp_upd_s || upd_w_cnt !== exp_upd_w)
            $display("FAIL clamp_top_update: got %0d/%0d pulses, expected %0d/%0d",
                     upd_s_cnt, upd_w_cnt, exp_upd_s, exp_upd_w);
        else pass_cnt++;
        press(0, 1, 0);
        total_cnt++;
        if ({values_s, values_w} !== {pack(0), pack(1)} || m_s[0] != 175)
            $display("FAIL first_dec_value: got %h %h, expected %h %h", values_s, values_w, pack(0), pack(1));
        else pass_cnt++;
        total_cnt++;
        if (upd_s_cnt !== exp_upd_s || upd_w_cnt !== exp_upd_w)
            $display("FAIL first_dec_update: got %0d/%0d pulses, expected %0d/%0d",
                     upd_s_cnt, upd_w_cnt, exp_upd_s, exp_upd_w);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 4; i++) begin
            int g = (i == 0) ? 2 : $urandom_range(1, DEB - 1);
            drive(0, 1, 0, g, DEB + 5);
            total_cnt++;
            if ({values_s, values_w} !== {pack(0), pack(1)} || upd_s_cnt !== exp_upd_s || upd_w_cnt !== exp_upd_w)
                $display("FAIL glitch_%0d_cycles: got %h %h upd %0d, expected %h %h upd %0d",
                         g, values_s, values_w, upd_s_cnt, pack(0), pack(1), exp_upd_s);
            else pass_cnt++;
        end
        // A low level lasting exactly the debounce window is a real press.
        drive(0, 1, 0, DEB, DEB + 5);
        model_press(0, 1, 0);
        total_cnt++;
        if ({values_s, values_w} !== {pack(0), pack(1)} || upd_s_cnt !== exp_upd_s)
            $display("FAIL deb_exact_press: got %h upd %0d, expected %h upd %0d",
                     values_s, upd_s_cnt, pack(0), exp_upd_s);
        else pass_cnt++;
    endtask

    task automatic test_select();
        do_reset();
        press(0, 0, 1);
        repeat (3) press(0, 1, 0);
        total_cnt++;
        if ({values_s, values_w, sel_s} !== {pack(0), pack(1), 3'(m_sel)} || m_s[1] != 165 || m_s[0] != VINIT)
            $display("FAIL select_ch1: got %h sel %0d, expected %h sel %0d", values_s, sel_s, pack(0), m_sel);
        else pass_cnt++;
        press(0, 0, 1);
        total_cnt++;
        if ({sel_s, sel_w} !== {3'(m_sel), 3'(m_sel)} || m_sel != 0)
            $display("FAIL select_rollover: got %0d/%0d, expected %0d", sel_s, sel_w, m_sel);
        else pass_cnt++;
    endtask

    task automatic test_bounds();
        do_reset();
        repeat ((VINIT - VMIN) / STEP) press(0, 1, 0);
        total_cnt++;
        if ({values_s, values_w} !== {pack(0), pack(1)} || m_s[0] != VMIN)
            $display("FAIL walk_to_vmin: got %h %h, expected %h %h", values_s, values_w, pack(0), pack(1));
        else pass_cnt++;
        press(0, 1, 0);
        total_cnt++;
        if ({values_s, values_w} !== {pack(0), pack(1)} || m_w[0] != VMAX || m_s[0] != VMIN)
            $display("FAIL below_vmin: got %h %h, expected %h %h", values_s, values_w, pack(0), pack(1));
        else pass_cnt++;
        press(1, 0, 0);
        total_cnt++;
        if ({values_s, values_w} !== {pack(0), pack(1)} || upd_s_cnt !== exp_upd_s || upd_w_cnt !== exp_upd_w)
            $display("FAIL above_vmax: got %h %h upd %0d/%0d, expected %h %h upd %0d/%0d", values_s, values_w,
                     upd_s_cnt, upd_w_cnt, pack(0), pack(1), exp_upd_s, exp_upd_w);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        press(1, 1, 0);
        total_cnt++;
        if ({values_s, values_w, sel_s} !== {pack(0), pack(1), 3'(m_sel)} || upd_s_cnt !== exp_upd_s)
            $display("FAIL inc_dec_same: got %h upd %0d, expected %h upd %0d", values_s, upd_s_cnt, pack(0), exp_upd_s);
        else pass_cnt++;
        press(1, 0, 1);
        total_cnt++;
        if ({values_s, values_w, sel_s, sel_w} !== {pack(0), pack(1), 3'(m_sel), 3'(m_sel)} || upd_w_cnt !== exp_upd_w)
            $display("FAIL sel_inc_same: got %h sel %0d, expected %h sel %0d", values_s, sel_s, pack(0), m_sel);
        else pass_cnt++;
    endtask

    task automatic test_held_through_reset();
        @(negedge clk);
        rst_n = 1'b0;
        dec_btn = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (25) @(negedge clk);
        dec_btn = 1'b1;
        repeat (DEB + 5) @(negedge clk);
        total_cnt++;
        if ({values_s, values_w, sel_s} !== {pack(0), pack(1), 3'(m_sel)} || upd_s_cnt !== exp_upd_s)
            $display("FAIL held_through_reset: got %h upd %0d, expected %h upd %0d",
                     values_s, upd_s_cnt, pack(0), exp_upd_s);
        else pass_cnt++;
        press(0, 1, 0);
        total_cnt++;
        if ({values_s, values_w} !== {pack(0), pack(1)} || upd_s_cnt !== exp_upd_s)
            $display("FAIL repress_after_reset: got %h upd %0d, expected %h upd %0d",
                     values_s, upd_s_cnt, pack(0), exp_upd_s);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int op = $urandom_range(0, 5);
            case (op)
                0: press(1, 0, 0);
                1: press(0, 1, 0);
                2: press(0, 0, 1);
                3: press(1, 1, 0);
                4: press($urandom_range(0, 1), 0, 1);
                default: drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                               $urandom_range(1, DEB - 1), DEB + 5);
            endcase
            total_cnt++;
            if ({values_s, values_w, sel_s, sel_w} !== {pack(0), pack(1), 3'(m_sel), 3'(m_sel)} ||
                upd_s_cnt !== exp_upd_s || upd_w_cnt !== exp_upd_w)
                $display("FAIL random_op%0d_step%0d: got %h %h sel %0d upd %0d/%0d, expected %h %h sel %0d upd %0d/%0d",
                         op, i, values_s, values_w, sel_s, upd_s_cnt, upd_w_cnt,
                         pack(0), pack(1), m_sel, exp_upd_s, exp_upd_w);
            else pass_cnt++;
        end
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int waited = 0;
        do_reset();
        repeat ((VINIT - VMIN) / STEP) press(0, 1, 0);
        upd_cyc.delete();
        @(negedge clk);
        inc_btn = 1'b0;
        while (upd_cyc.size() == 0 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        total_cnt++;
        if (upd_cyc.size() == 0) begin
            $display("FAIL repeat_first_event: got no update in 30 cycles, expected one");
        end else begin
            pass_cnt++;
            repeat (RPT_DLY + 2 * RPT_PER + 2) @(negedge clk);
            for (int i = 0; i < 4; i++) model_press(1, 0, 0);
            total_cnt++;
            if (upd_cyc.size() != 4 ||
                upd_cyc[1] - upd_cyc[0] != RPT_DLY ||
                upd_cyc[2] - upd_cyc[0] != RPT_DLY + RPT_PER ||
                upd_cyc[3] - upd_cyc[0] != RPT_DLY + 2 * RPT_PER)
                $display("FAIL repeat_timing: got %0d pulses at %p, expected offsets 0,%0d,%0d,%0d",
                         upd_cyc.size(), upd_cyc, RPT_DLY, RPT_DLY + RPT_PER, RPT_DLY + 2 * RPT_PER);
            else pass_cnt++;
            total_cnt++;
            if ({values_s, values_w} !== {pack(0), pack(1)} || m_s[0] != 50)
                $display("FAIL repeat_value: got %h %h, expected %h %h", values_s, values_w, pack(0), pack(1));
            else pass_cnt++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        upd_cyc.delete();
        repeat (RPT_DLY + 2 * RPT_PER) @(negedge clk);
        inc_btn = 1'b1;
        repeat (DEB + 5) @(negedge clk);
        total_cnt++;
        if ({values_s, values_w, sel_s} !== {pack(0), pack(1), 3'(m_sel)} || upd_cyc.size() != 0)
            $display("FAIL repeat_reset_midhold: got %h with %0d pulses, expected %h with 0",
                     values_s, upd_cyc.size(), pack(0));
        else pass_cnt++;
        press(0, 1, 0);
        total_cnt++;
        if ({values_s, values_w} !== {pack(0), pack(1)})
            $display("FAIL repeat_repress: got %h %h, expected %h %h", values_s, values_w, pack(0), pack(1));
        else pass_cnt++;
    endtask
`else
    task automatic test_single_step();
        do_reset();
        press(0, 1, 0);
        drive(1, 0, 0, 80, DEB + 5);
        model_press(1, 0, 0);
        drive(0, 1, 0, 80, DEB + 5);
        model_press(0, 1, 0);
        total_cnt++;
        if ({values_s, values_w} !== {pack(0), pack(1)} || upd_s_cnt !== exp_upd_s || upd_w_cnt !== exp_upd_w)
            $display("FAIL long_hold_single_step: got %h upd %0d, expected %h upd %0d",
                     values_s, upd_s_cnt, pack(0), exp_upd_s);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_clamp_top();
        test_glitch();
        test_select();
        test_bounds();
        test_simultaneous();
        test_held_through_reset();
        test_random();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`else
        test_single_step();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
